// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous SRAM between the CPU memory path and
// an auxiliary requester (memory loader / debug port).
//
// Round-robin arbitration between the two ports. Every access is a fixed
// sequence: a grant in IDLE, READ_CYCLES or WRITE_CYCLES cycles in ACCESS,
// then one DONE cycle that carries the one-cycle ack. Every output is a flop.
//
// Ports
//   Clk, Reset                     system clock, synchronous active-high reset
//   cpu_req/we/addr/wdata          CPU request; held stable until cpu_ack
//   cpu_ack, cpu_rdata             completion pulse; read data held until the next CPU read
//   aux_req/we/addr/wdata          auxiliary request, same protocol as the CPU port
//   aux_ack, aux_rdata             auxiliary completion and read data
//   sram_addr, sram_wdata          SRAM address and write data
//   sram_wdrive                    1 = top level drives sram_wdata onto the data pins
//   sram_rdata                     data from the SRAM pins
//   sram_ce_n, sram_oe_n, sram_we_n  active-low SRAM strobes
//   busy                           1 whenever the FSM is not in IDLE
//
// state  | meaning
// IDLE   | waiting for a request; the grant and the request fields are latched here
// ACCESS | SRAM strobes active; the counter runs down to 1
// DONE   | ack pulse to the granted port; strobes released
module sram_arbiter #(
    parameter int ADDR_W       = 20,
    parameter int DATA_W       = 16,
    parameter int READ_CYCLES  = 2,
    parameter int WRITE_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_ack,
    output logic [DATA_W-1:0] aux_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_wdrive,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

    localparam int MAX_CYCLES = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(READ_CYCLES);
    localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WRITE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_AUX = 1'b1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic                we_q, we_d;
    // The SRAM address/data output flops double as the latched request fields.
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]   sram_wdata_q, sram_wdata_d;
    logic                cpu_ack_q, cpu_ack_d, aux_ack_q, aux_ack_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d, aux_rdata_q, aux_rdata_d;
    logic                sram_wdrive_q, sram_wdrive_d;
    logic                sram_ce_n_q, sram_ce_n_d;
    logic                sram_oe_n_q, sram_oe_n_d;
    logic                sram_we_n_q, sram_we_n_d;
    logic                busy_q, busy_d;
    logic                pick_aux;
    logic                read_last;

    // AUX wins when it is the only requester, or on a tie when the CPU went last.
    assign pick_aux  = aux_req && (!cpu_req || (last_grant_q == GRANT_CPU));
    assign read_last = (state_q == ST_ACCESS) && (cnt_q == CNT_LAST) && !we_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            grant_q       <= GRANT_CPU;
            last_grant_q  <= GRANT_AUX;
            we_q          <= 1'b0;
            sram_addr_q   <= '0;
            sram_wdata_q  <= '0;
            cpu_ack_q     <= 1'b0;
            aux_ack_q     <= 1'b0;
            cpu_rdata_q   <= '0;
            aux_rdata_q   <= '0;
            sram_wdrive_q <= 1'b0;
            sram_ce_n_q   <= 1'b1;
            sram_oe_n_q   <= 1'b1;
            sram_we_n_q   <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            we_q          <= we_d;
            sram_addr_q   <= sram_addr_d;
            sram_wdata_q  <= sram_wdata_d;
            cpu_ack_q     <= cpu_ack_d;
            aux_ack_q     <= aux_ack_d;
            cpu_rdata_q   <= cpu_rdata_d;
            aux_rdata_q   <= aux_rdata_d;
            sram_wdrive_q <= sram_wdrive_d;
            sram_ce_n_q   <= sram_ce_n_d;
            sram_oe_n_q   <= sram_oe_n_d;
            sram_we_n_q   <= sram_we_n_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req || aux_req) begin
                    grant_d      = pick_aux ? GRANT_AUX : GRANT_CPU;
                    we_d         = pick_aux ? aux_we    : cpu_we;
                    sram_addr_d  = pick_aux ? aux_addr  : cpu_addr;
                    sram_wdata_d = pick_aux ? aux_wdata : cpu_wdata;
                    cnt_d        = we_d ? WR_LOAD : RD_LOAD;
                    last_grant_d = grant_d;
                    state_d      = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q - CNT_LAST;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    // In ACCESS, cnt_d counts down to 1 in the last cycle, which is where we_n
    // rises to give the write its address/data hold cycle.
    always_comb begin
        sram_ce_n_d   = !(state_d == ST_ACCESS);
        sram_oe_n_d   = !((state_d == ST_ACCESS) && !we_d);
        sram_we_n_d   = !((state_d == ST_ACCESS) && we_d && (cnt_d != CNT_LAST));
        sram_wdrive_d = (state_d == ST_ACCESS) && we_d;
        busy_d        = (state_d != ST_IDLE);
        cpu_ack_d     = (state_d == ST_DONE) && (grant_q == GRANT_CPU);
        aux_ack_d     = (state_d == ST_DONE) && (grant_q == GRANT_AUX);
        cpu_rdata_d   = cpu_rdata_q;
        aux_rdata_d   = aux_rdata_q;
        if (read_last && (grant_q == GRANT_CPU)) cpu_rdata_d = sram_rdata;
        if (read_last && (grant_q == GRANT_AUX)) aux_rdata_d = sram_rdata;
    end

    assign cpu_ack     = cpu_ack_q;
    assign aux_ack     = aux_ack_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign aux_rdata   = aux_rdata_q;
    assign sram_addr   = sram_addr_q;
    assign sram_wdata  = sram_wdata_q;
    assign sram_wdrive = sram_wdrive_q;
    assign sram_ce_n   = sram_ce_n_q;
    assign sram_oe_n   = sram_oe_n_q;
    assign sram_we_n   = sram_we_n_q;
    assign busy        = busy_q;

endmodule
